// File: rtl/test_ctrl_if.sv
// ---------------------------------------------------------------------------
// test_ctrl_if -- single-cycle register bus used to talk to test_ctrl.
//
// Signals (directions seen from the slave):
//   req_i    in   1   access request, one access per cycle
//   we_i     in   1   write enable, qualified by req_i
//   addr_i   in   8   byte offset, bits [1:0] ignored
//   wdata_i  in  32   write data
//   rdata_o  out 32   read data, valid with ready_o, 0 otherwise
//   ready_o  out  1   access-complete strobe, one cycle after req_i
// ---------------------------------------------------------------------------
interface test_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ready_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ready_o
    );
endinterface

// File: rtl/test_ctrl.sv
// ---------------------------------------------------------------------------
// test_ctrl -- simulation/test controller with TOHOST pass/fail mailbox,
// watchdog, RUN-cycle counter and a small bank of signature registers.
//
// Ports:
//   clk_i        in   1      sole clock, rising edge
//   rst_i        in   1      asynchronous active-high reset
//   bus          slave       register bus (see test_ctrl_if)
//   done_o       out  1      test terminated (pass, fail or timeout)
//   pass_o       out  1      test passed
//   timeout_o    out  1      watchdog expired
//   fail_code_o  out 31      TOHOST value [31:1] of a failing write
//   cycle_o      out CNT_W   cycles spent in RUN (saturating)
//
// Register map (word aligned byte offsets):
//   0x00 TOHOST (W)  0x04 STATUS (R)  0x08 CYCLE (R)  0x0C KICK (W)
//   0x10 + 4*i SIG[i] (R/W), i < NUM_SIG
// ---------------------------------------------------------------------------
module test_ctrl #(
    parameter int NUM_SIG     = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    test_ctrl_if.slave        bus,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [30:0]       fail_code_o,
    output logic [CNT_W-1:0]  cycle_o
);

    localparam int          WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYC);

    // Word indices (addr_i[7:2]) of the fixed registers.
    localparam logic [5:0] ADDR_TOHOST = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_CYCLE  = 6'h02;
    localparam logic [5:0] ADDR_KICK   = 6'h03;
    localparam logic [5:0] ADDR_SIG0   = 6'h04;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } state_t;

    state_t             r_state;
    logic [WD_W-1:0]    r_wdog;
    logic [CNT_W-1:0]   r_cycle;
    logic               r_done;
    logic               r_pass;
    logic               r_tmo;
    logic [30:0]        r_fail_code;
    logic [31:0]        r_sig [NUM_SIG];
    logic               r_ready;
    logic [31:0]        r_rdata;

    logic [5:0]         w_word;
    logic [5:0]         w_sig_off;
    logic               w_sig_hit;
    logic               w_wr;
    logic               w_tohost_wr;
    logic               w_kick_wr;
    logic               w_run;
    logic [31:0]        w_status;
    logic [31:0]        w_cycle32;
    logic [31:0]        w_rdata_nxt;
    logic               w_unused_addr;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_word        = bus.addr_i[7:2];
    assign w_unused_addr = ^bus.addr_i[1:0];
    assign w_sig_off     = w_word - ADDR_SIG0;
    assign w_sig_hit     = (w_word >= ADDR_SIG0) && (w_sig_off < 6'(NUM_SIG));
    assign w_wr          = bus.req_i & bus.we_i;
    assign w_tohost_wr   = w_wr && (w_word == ADDR_TOHOST);
    assign w_kick_wr     = w_wr && (w_word == ADDR_KICK);
    assign w_run         = (r_state == ST_RUN);

    assign w_status  = {28'd0, r_tmo, (r_state == ST_FAIL), r_pass, r_done};
    assign w_cycle32 = 32'(r_cycle);

    // Read mux: write cycles, write-only and unmapped words all return 0.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // can leave it unassigned and infer a latch.
        w_rdata_nxt = '0;
        if (!bus.we_i) begin
            case (w_word)
                ADDR_STATUS: w_rdata_nxt = w_status;
                ADDR_CYCLE:  w_rdata_nxt = w_cycle32;
                default: begin
                    for (int i = 0; i < NUM_SIG; i++) begin
                        if (w_sig_hit && (w_sig_off == 6'(i))) begin
                            w_rdata_nxt = r_sig[i];
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus response: ready and data are registered together, one cycle
    // after every request, with no back-pressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= bus.req_i;
            r_rdata <= bus.req_i ? w_rdata_nxt : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM with watchdog, cycle counter and registered flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_wdog      <= WD_RELOAD;
            r_cycle     <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_tmo       <= 1'b0;
            r_fail_code <= '0;
        end else if (w_run) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // read in this block sees the pre-edge value.
            if (r_cycle != '1) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end

            if (w_kick_wr) begin
                r_wdog <= WD_RELOAD;
            end else if (r_wdog != '0) begin
                r_wdog <= r_wdog - WD_W'(1);
            end

            // TOHOST beats expiry; a KICK in the expiry cycle cancels it.
            if (w_tohost_wr && bus.wdata_i[0]) begin
                r_done <= 1'b1;
                if (bus.wdata_i == 32'd1) begin
                    r_state <= ST_PASS;
                    r_pass  <= 1'b1;
                end else begin
                    r_state     <= ST_FAIL;
                    r_fail_code <= bus.wdata_i[31:1];
                end
            end else if (!w_kick_wr && (r_wdog == WD_W'(1))) begin
                r_state <= ST_TMO;
                r_done  <= 1'b1;
                r_tmo   <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Signature registers: writable only while the test is running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: this small register bank is cleared on reset so a new
            // test never sees stale signatures; larger RAM-style storage
            // would normally be left unreset.
            for (int i = 0; i < NUM_SIG; i++) begin
                r_sig[i] <= '0;
            end
        end else if (w_run && w_wr) begin
            for (int i = 0; i < NUM_SIG; i++) begin
                if (w_sig_hit && (w_sig_off == 6'(i))) begin
                    r_sig[i] <= bus.wdata_i;
                end
            end
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.rdata_o = r_rdata;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign timeout_o   = r_tmo;
    assign fail_code_o = r_fail_code;
    assign cycle_o     = r_cycle;

endmodule
